// File: rtl/spi_adc_responder.sv
// spi_adc_responder: ADC end of the DAQ serial link.
// Watches the master's adc_cs / adc_sclk (both asynchronous to clk) through
// synchronizers, and shifts a DATA_W-bit sample out MSB-first on adc_dout.
// Samples arrive through a single-entry holding register with valid/ready.
//
// Handshake: a sample transfers on any clk edge where sample_valid and
// sample_ready are both high; sample_ready is simply "holding register empty".
//
// Build option: define SPI_ADC_RESP_RAMP_EN to replace the holding register
// with a free-running ramp that advances once per completed frame.
//
// SYNC_STAGES must be at least 2.
module spi_adc_responder #(
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              adc_cs,
  input  logic              adc_sclk,
  output logic              adc_dout,
  input  logic [DATA_W-1:0] sample_din,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              frame_done,
  output logic              frame_abort,
  output logic              stale,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync, sclk_sync;
  logic                   cs_d, sclk_d;
  logic                   cs_s, sclk_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;
  logic                   frame_start, last_rise, abort_ev;
  logic [DATA_W-1:0]      shreg, load_word;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   done_q, abort_q;

  // Synchronizers plus one edge-detect flop; reset to the idle pin levels
  // so leaving reset with the bus idle produces no spurious edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cs_sync   <= '1;
      cs_d      <= 1'b1;
      sclk_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
      cs_d      <= cs_sync[SYNC_STAGES-1];
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], adc_sclk};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  // Frame events; a cs edge always wins over an sclk edge in the same cycle.
  assign frame_start = (state_q == IDLE) && cs_fall;
  assign abort_ev    = (state_q == SHIFT) && cs_rise;
  assign last_rise   = (state_q == SHIFT) && !cs_rise && sclk_rise && (bit_cnt == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_fall) state_d = SHIFT;
      SHIFT:   if (cs_rise) state_d = IDLE;
               else if (last_rise) state_d = DONE;
      DONE:    if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: data only drives while shifting; pulses are registered events.
  always_comb begin
    adc_dout    = 1'b0;
    if (state_q == SHIFT) adc_dout = shreg[DATA_W-1];
    frame_done  = done_q;
    frame_abort = abort_q;
    fsm_state   = state_q;
  end

  // Shift register, bit counter and one-cycle frame pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= last_rise;
      abort_q <= abort_ev;
      if (frame_start) begin
        shreg   <= load_word;
        bit_cnt <= CNT_TOP;
      end else if (state_q == SHIFT) begin
        if (sclk_rise && bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        if (sclk_fall) shreg <= {shreg[DATA_W-2:0], 1'b0};
      end
    end
  end

`ifdef SPI_ADC_RESP_RAMP_EN
  logic [DATA_W-1:0] ramp_q;
  logic              unused_inputs;

  assign unused_inputs = ^{sample_din, sample_valid};
  assign load_word     = ramp_q;
  assign sample_ready  = 1'b0;
  assign stale         = 1'b0;

  // Ramp advances only on completed frames, never on aborts; wraps naturally.
  always_ff @(posedge clk) begin
    if (!reset_n)       ramp_q <= '0;
    else if (last_rise) ramp_q <= ramp_q + DATA_W'(1);
  end
`else
  logic [DATA_W-1:0] hold_q;
  logic              hold_full_q, stale_q, hs;

  assign sample_ready = !hold_full_q;
  assign hs           = sample_valid && sample_ready;
  assign load_word    = hold_q;
  assign stale        = stale_q;

  // Holding register. hold_q is never cleared, so an empty register still
  // carries the last sample sent and a frame with nothing new re-sends it.
  // A handshake coinciding with frame start is kept for the next frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      stale_q     <= 1'b0;
    end else begin
      if (hs) hold_q <= sample_din;
      if (frame_start) begin
        hold_full_q <= hs;
        stale_q     <= !hold_full_q;
      end else if (hs) begin
        hold_full_q <= 1'b1;
      end
    end
  end
`endif

endmodule
